// File: rtl/vga_paint_pkg.sv
// Shared constants and types for the VGA paint pipeline: screen geometry,
// pixel field widths, requester indices and the write-arbiter state encoding.
package vga_paint_pkg;
  localparam int SCREEN_WIDTH  = 320;
  localparam int SCREEN_HEIGHT = 240;
  localparam int X_W           = 9;
  localparam int Y_W           = 8;
  localparam int COLOR_W       = 9;
  localparam int NUM_REQ       = 3;

  localparam logic [COLOR_W-1:0] COLOR_BACKGROUND = 9'h1FF;

  localparam int REQ_CLEAR = 0;
  localparam int REQ_BRUSH = 1;
  localparam int REQ_STAMP = 2;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  function automatic logic in_bounds(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (32'(x) < 32'(SCREEN_WIDTH)) && (32'(y) < 32'(SCREEN_HEIGHT));
  endfunction
endpackage

// File: rtl/vga_write_arbiter_if.sv
// Pixel request bundle between the three producers and the write arbiter.
// Fields are packed per requester: requester i lives at [i*W +: W].
interface vga_write_arbiter_if;
  import vga_paint_pkg::*;

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*X_W-1:0]     req_x;
  logic [NUM_REQ*Y_W-1:0]     req_y;
  logic [NUM_REQ*COLOR_W-1:0] req_color;
  logic                       lock0;

  modport master (
    output req_valid, req_x, req_y, req_color, lock0,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_x, req_y, req_color, lock0,
    output req_ready
  );
endinterface

// File: rtl/vga_rr_grant2.sv
// Two-way round-robin grant. The pointer favours lane 0 after reset and
// moves to the other lane whenever a lane is granted (grant implies transfer).
module vga_rr_grant2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);
  logic ptr_reg;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (!ptr_reg)
        grant = valid[0] ? 2'b01 : (valid[1] ? 2'b10 : 2'b00);
      else
        grant = valid[1] ? 2'b10 : (valid[0] ? 2'b01 : 2'b00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr_reg <= 1'b0;
    else if (grant[0])
      ptr_reg <= 1'b1;
    else if (grant[1])
      ptr_reg <= 1'b0;
  end
endmodule

// File: rtl/vga_write_arbiter.sv
// Shares the vga_adapter pixel-write port: clear engine has priority and may
// lock the port; brush and stamp engines alternate. Output is registered.
module vga_write_arbiter
  import vga_paint_pkg::*;
(
  input  logic                CLOCK_50,
  input  logic                resetn,
  vga_write_arbiter_if.slave  req,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOR_W-1:0]  vga_color,
  output logic                vga_write,
  output logic                locked,
  output logic [15:0]         drop_count
);
  arb_state_t           state_reg;
  logic                 locked_reg;
  logic [X_W-1:0]       vga_x_reg;
  logic [Y_W-1:0]       vga_y_reg;
  logic [COLOR_W-1:0]   vga_color_reg;
  logic                 vga_write_reg;
  logic [15:0]          drop_count_reg;

  logic [NUM_REQ-1:0]   ready;
  logic [1:0]           rr_grant;
  logic                 rr_en;
  logic                 xfer;
  logic [X_W-1:0]       sel_x;
  logic [Y_W-1:0]       sel_y;
  logic [COLOR_W-1:0]   sel_color;

  assign rr_en = resetn && (state_reg == ARB_IDLE) && !req.req_valid[REQ_CLEAR];

  vga_rr_grant2 u_rr (
    .clk   (CLOCK_50),
    .rst_n (resetn),
    .en    (rr_en),
    .valid (req.req_valid[REQ_STAMP:REQ_BRUSH]),
    .grant (rr_grant)
  );

  // Grants are suppressed while reset is held so no producer advances.
  always_comb begin
    ready = '0;
    if (resetn) begin
      case (state_reg)
        ARB_IDLE: begin
          if (req.req_valid[REQ_CLEAR])
            ready[REQ_CLEAR] = 1'b1;
          else
            ready[REQ_STAMP:REQ_BRUSH] = rr_grant;
        end
        ARB_LOCKED: ready[REQ_CLEAR] = req.req_valid[REQ_CLEAR];
        default:    ready = '0;
      endcase
    end
  end

  assign req.req_ready = ready;
  assign xfer          = |ready;

  always_comb begin
    sel_x     = req.req_x[REQ_CLEAR*X_W +: X_W];
    sel_y     = req.req_y[REQ_CLEAR*Y_W +: Y_W];
    sel_color = req.req_color[REQ_CLEAR*COLOR_W +: COLOR_W];
    for (int i = 1; i < NUM_REQ; i++) begin
      if (ready[i]) begin
        sel_x     = req.req_x[i*X_W +: X_W];
        sel_y     = req.req_y[i*Y_W +: Y_W];
        sel_color = req.req_color[i*COLOR_W +: COLOR_W];
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= ARB_IDLE;
      locked_reg     <= 1'b0;
      vga_x_reg      <= '0;
      vga_y_reg      <= '0;
      vga_color_reg  <= '0;
      vga_write_reg  <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (ready[REQ_CLEAR] && req.lock0) begin
            state_reg  <= ARB_LOCKED;
            locked_reg <= 1'b1;
          end
        end
        ARB_LOCKED: begin
          if (!req.lock0) begin
            state_reg  <= ARB_IDLE;
            locked_reg <= 1'b0;
          end
        end
        default: begin
          state_reg  <= ARB_IDLE;
          locked_reg <= 1'b0;
        end
      endcase

      vga_write_reg <= 1'b0;
      if (xfer) begin
        vga_x_reg     <= sel_x;
        vga_y_reg     <= sel_y;
        vga_color_reg <= sel_color;
        if (in_bounds(sel_x, sel_y))
          vga_write_reg <= 1'b1;
        else if (drop_count_reg != 16'hFFFF)
          drop_count_reg <= drop_count_reg + 16'd1;
      end
    end
  end

  assign vga_x      = vga_x_reg;
  assign vga_y      = vga_y_reg;
  assign vga_color  = vga_color_reg;
  assign vga_write  = vga_write_reg;
  assign locked     = locked_reg;
  assign drop_count = drop_count_reg;
endmodule

// File: doc/vga_write_arbiter.md
Name: vga_write_arbiter

Overview:
Shares the single pixel-write port of vga_adapter among three pixel producers: screen-clear engine (requester 0), brush/square drawing engine (requester 1) and a stamp/fill engine (requester 2). Requester 0 has fixed priority and can lock the port for a full-frame clear. Requesters 1 and 2 alternate round-robin. Accepted pixels are bounds-checked and registered onto the vga_adapter write interface.

Parameters:
SCREEN_WIDTH, 320, visible pixels per row; x must be < this
SCREEN_HEIGHT, 240, visible rows; y must be < this
X_W, 9, x coordinate width
Y_W, 8, y coordinate width
COLOR_W, 9, colour width (3R/3G/3B)

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
resetn  in  1  asynchronous, active-low reset
req_valid  in  3  per-requester pixel valid, bit i = requester i
req_ready  out  3  per-requester grant; a transfer occurs when valid[i] & ready[i]
req_x  in  3*X_W  packed x; requester i at [i*X_W +: X_W]
req_y  in  3*Y_W  packed y; same packing
req_color  in  3*COLOR_W  packed colour; same packing
lock0  in  1  requester 0 holds the port while high
vga_x  out  X_W  registered x to vga_adapter
vga_y  out  Y_W  registered y to vga_adapter
vga_color  out  COLOR_W  registered colour to vga_adapter
vga_write  out  1  registered write strobe, one cycle per pixel
locked  out  1  high while in LOCKED state
drop_count  out  16  saturating count of accepted out-of-range pixels

Behaviour:
- Reset (resetn low, asynchronous): vga_write=0, vga_x=0, vga_y=0, vga_color=0, locked=0, drop_count=0, state=IDLE, rr_ptr=1. req_ready is 0 while reset is asserted.
- req_ready is combinational from the current state, rr_ptr and req_valid. At most one bit is high. A bit is never high without the matching valid.
- States:
  - IDLE:
    - If valid[0], grant 0.
    - Otherwise grant rr_ptr if its valid is high, else the other of {1,2} if its valid is high.
    - On accepting from 0 with lock0=1, go to LOCKED.
  - LOCKED:
    - Only requester 0 can be granted; ready[0]=valid[0]. Requesters 1 and 2 are stalled even when 0 has valid gaps.
    - When lock0=0 at a clock edge, return to IDLE. A transfer from 0 in that same cycle is still accepted.
  - locked output = (state==LOCKED), registered.
- rr_ptr update: after accepting from 1, rr_ptr=2; after accepting from 2, rr_ptr=1. Grants to 0 leave rr_ptr unchanged.
- Output stage:
  - On the edge after an accepted transfer, vga_x, vga_y and vga_color load the granted values.
  - vga_write=1 only if x<SCREEN_WIDTH and y<SCREEN_HEIGHT.
  - Latency: 1 cycle. Throughput: 1 pixel per cycle, no bubbles.
- No transfer in a cycle: vga_write=0 on the next edge; vga_x, vga_y and vga_color hold.
- Out-of-range transfer: it is still accepted (ready high, producer advances). vga_write=0, coordinate/colour registers still load, drop_count increments and saturates at 16'hFFFF.
- Simultaneous events:
  - valid[0] together with valid[1]/valid[2] in IDLE: 0 wins.
  - valid[1] and valid[2] together: rr_ptr decides.
  - lock0 high with valid[0] low in IDLE: no lock (lock is entered only on an accepted transfer from 0).
- Reset mid-burst: in-flight write is discarded, lock is released, and producers must restart their own sequence.
- The arbiter never modifies coordinates; producers present final screen coordinates.

Decomposition:
- Shared package (vga_paint_pkg): SCREEN_WIDTH, SCREEN_HEIGHT, X_W, Y_W, COLOR_W, COLOR_BACKGROUND=9'h1FF, requester index constants REQ_CLEAR=0, REQ_BRUSH=1, REQ_STAMP=2, state encoding ARB_IDLE/ARB_LOCKED.
- One natural sub-module: vga_rr_grant2, the two-way round-robin grant with pointer, reused by future requesters.
- Output register stage and drop counter stay inline.

Test Plan:
- Reset, then valid[1]=1 with (10,20,9'h007) held 1 cycle -> ready[1]=1 that cycle; next edge vga_write=1, vga_x=10, vga_y=20, vga_color=9'h007.
- valid[1] and valid[2] both held for 4 cycles from reset -> grants alternate 1,2,1,2; four consecutive vga_write pulses.
- valid[0] with lock0=1 for 3 pixels, one valid gap, while valid[1] is held -> ready[1]=0 throughout, locked=1; after lock0 drops, the next cycle grants 1.
- valid[2] with x=320, y=5 -> ready[2]=1, vga_write=0, drop_count 0->1. Repeat with y=240 -> drop_count=2.
- valid[0], valid[1] and valid[2] all high in IDLE with lock0=0 -> ready=3'b001, and rr_ptr is unchanged afterward.
- Assert resetn low mid-LOCKED burst -> immediately vga_write=0, locked=0, req_ready=0; after release, IDLE with rr_ptr=1.
